mips_instr_encoder: RTL

Streaming MIPS instruction encoder: the inverse of the control decoder. It accepts symbolic instruction requests (operation code plus register, immediate and target fields) over a valid/ready handshake. It packs each request into a 32-bit machine word, resolves branch and jump targets against an internal program counter, and presents the results through a 2-entry output FIFO. It sits between the testbench or boot loader and the instruction memory write port.

---
 rtl/mips_instr_encoder.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/mips_instr_encoder.sv
// ---------------------------------------------------------------------------
// mips_instr_encoder
//
// Streaming MIPS instruction encoder. Symbolic requests (operation code plus
// register, immediate and target fields) arrive over a valid/ready handshake.
// Each request is packed into a 32-bit machine word, tagged with the current
// program counter and queued in a 2-entry output FIFO.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high reset
//   in_valid   in   1   request valid
//   in_ready   out  1   request accepted when in_valid & in_ready
//   in_op      in   5   operation code (0..16 legal, 17..31 illegal)
//   in_rs      in   5   source register
//   in_rt      in   5   target register
//   in_rd      in   5   destination register
//   in_shamt   in   5   shift amount (sll only)
//   in_imm     in   16  immediate (ori, loads, stores, lui)
//   in_target  in   32  absolute byte address (beq, jal, j)
//   base_load  in   1   reload the program counter
//   base_addr  in   32  new program counter (bits [1:0] forced to 0)
//   out_valid  out  1   FIFO head valid
//   out_ready  in   1   head consumed when out_valid & out_ready
//   out_instr  out  32  encoded word
//   out_addr   out  32  program counter assigned to the word
//   out_err    out  1   illegal operation or unencodable target
// ---------------------------------------------------------------------------
module mips_instr_encoder #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [31:0] in_target,
    input  logic        base_load,
    input  logic [31:0] base_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err
);

    typedef enum logic [4:0] {
        OP_ADDU = 5'd0,
        OP_SUBU = 5'd1,
        OP_ORI  = 5'd2,
        OP_LW   = 5'd3,
        OP_SW   = 5'd4,
        OP_LH   = 5'd5,
        OP_LHU  = 5'd6,
        OP_LB   = 5'd7,
        OP_LBU  = 5'd8,
        OP_SH   = 5'd9,
        OP_SB   = 5'd10,
        OP_BEQ  = 5'd11,
        OP_LUI  = 5'd12,
        OP_JAL  = 5'd13,
        OP_J    = 5'd14,
        OP_JR   = 5'd15,
        OP_SLL  = 5'd16
    } op_e;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_LH    = 6'h21;
    localparam logic [5:0] OPC_LHU   = 6'h25;
    localparam logic [5:0] OPC_LB    = 6'h20;
    localparam logic [5:0] OPC_LBU   = 6'h24;
    localparam logic [5:0] OPC_SH    = 6'h29;
    localparam logic [5:0] OPC_SB    = 6'h28;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_J     = 6'h02;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_SLL  = 6'h00;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [31:0] r_pc;
    logic [31:0] r_instr_q [2];
    logic [31:0] r_addr_q  [2];
    logic        r_err_q   [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    // -----------------------------------------------------------------------
    // Encoder datapath
    // -----------------------------------------------------------------------
    op_e         w_op;
    logic [31:0] w_pc4;
    logic [31:0] w_br_off;
    logic        w_br_err;
    logic        w_j_err;
    logic [31:0] w_instr;
    logic        w_err;
    logic        w_push;
    logic        w_pop;

    assign w_op  = op_e'(in_op);
    assign w_pc4 = r_pc + 32'd4;

    // Branch offset is relative to the delay-slot address (pc+4). It is
    // encodable when word-aligned and the bits above bit 17 are a pure sign
    // extension, i.e. the value lies in [-2^17, 2^17-4].
    assign w_br_off = in_target - w_pc4;
    assign w_br_err = (|w_br_off[1:0])
                    | ~((w_br_off[31:17] == '0) || (w_br_off[31:17] == '1));

    // Jumps can only reach the 256 MB region that contains pc+4.
    assign w_j_err = (in_target[31:28] != w_pc4[31:28]) | (|in_target[1:0]);

    always_comb begin
        w_instr = '0;
        w_err   = 1'b0;
        case (w_op)
            OP_ADDU: w_instr = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_ADDU};
            OP_SUBU: w_instr = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_SUBU};
            OP_ORI:  w_instr = {OPC_ORI, in_rs, in_rt, in_imm};
            OP_LW:   w_instr = {OPC_LW,  in_rs, in_rt, in_imm};
            OP_SW:   w_instr = {OPC_SW,  in_rs, in_rt, in_imm};
            OP_LH:   w_instr = {OPC_LH,  in_rs, in_rt, in_imm};
            OP_LHU:  w_instr = {OPC_LHU, in_rs, in_rt, in_imm};
            OP_LB:   w_instr = {OPC_LB,  in_rs, in_rt, in_imm};
            OP_LBU:  w_instr = {OPC_LBU, in_rs, in_rt, in_imm};
            OP_SH:   w_instr = {OPC_SH,  in_rs, in_rt, in_imm};
            OP_SB:   w_instr = {OPC_SB,  in_rs, in_rt, in_imm};
            OP_BEQ: begin
                // Truncated offset is emitted even when flagged.
                w_instr = {OPC_BEQ, in_rs, in_rt, w_br_off[17:2]};
                w_err   = w_br_err;
            end
            OP_LUI:  w_instr = {OPC_LUI, 5'd0, in_rt, in_imm};
            OP_JAL: begin
                w_instr = {OPC_JAL, in_target[27:2]};
                w_err   = w_j_err;
            end
            OP_J: begin
                w_instr = {OPC_J, in_target[27:2]};
                w_err   = w_j_err;
            end
            OP_JR:   w_instr = {OPC_RTYPE, in_rs, 5'd0, 5'd0, 5'd0, FN_JR};
            OP_SLL:  w_instr = {OPC_RTYPE, 5'd0, in_rt, in_rd, in_shamt, FN_SLL};
            default: begin
                w_instr = '0;
                w_err   = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Handshakes: in_ready depends only on the registered count.
    // -----------------------------------------------------------------------
    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // -----------------------------------------------------------------------
    // Program counter: base_load wins over the +4 advance; a request accepted
    // on the same edge has already been tagged with the old value.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (base_load) begin
            r_pc <= base_addr & ~32'd3;
        end else if (w_push) begin
            r_pc <= w_pc4;
        end
    end

    // -----------------------------------------------------------------------
    // Output FIFO
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_instr_q[i] <= '0;
                r_addr_q[i]  <= '0;
                r_err_q[i]   <= 1'b0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_instr_q[r_wr_ptr] <= w_instr;
                r_addr_q[r_wr_ptr]  <= r_pc;
                r_err_q[r_wr_ptr]   <= w_err;
                r_wr_ptr            <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_instr = r_instr_q[r_rd_ptr];
    assign out_addr  = r_addr_q[r_rd_ptr];
    assign out_err   = r_err_q[r_rd_ptr];

endmodule
